i2c_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one I2C write engine (16-bit register address, 8-bit data, start pulse, done pulse) between NREQ independent configuration requesters.
- Sits between the register-programming sequencers (memory-driven init, runtime tuning, debug) and the I2C wrapper.
- Latches the winning request, issues a single-cycle start, waits for done, acknowledges the requester, then enforces an inter-transaction gap.

---
 rtl/i2c_req_arbiter_if.sv | 27 ++
 rtl/i2c_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Bus bundle between the configuration requesters, the arbiter and the I2C write engine.
// master = arbiter side, slave = requester/engine side.
interface i2c_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_addr;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    err;
  logic [15:0]        i2c_addr;
  logic [7:0]         i2c_data;
  logic               i2c_start;
  logic               i2c_done;
  logic               busy;

  modport master (
    input  req, req_addr, req_data, i2c_done,
    output gnt, ack, err, i2c_addr, i2c_data, i2c_start, busy
  );

  modport slave (
    output req, req_addr, req_data, i2c_done,
    input  gnt, ack, err, i2c_addr, i2c_data, i2c_start, busy
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C write engine among NREQ requesters.
// Optional WAIT_DONE watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
  parameter int          NREQ           = 4,
  parameter int          GAP_CYCLES     = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'h493E00
) (
  input  logic               clk,
  input  logic               reset,
  i2c_req_arbiter_if.master  bus
);

  localparam int PW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            any_req_s;
  logic [PW-1:0]   sel_s;
  logic [15:0]     addr_sel_s;
  logic [7:0]      data_sel_s;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [NREQ-1:0] err_q, err_d;
  logic [23:0]     wdog_q, wdog_d;
`else
  logic            unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first active request at or after the pointer, with wrap.
  always_comb begin
    int   idx;
    logic hit;
    idx        = 0;
    hit        = 1'b0;
    any_req_s  = 1'b0;
    sel_s      = '0;
    addr_sel_s = 16'h0000;
    data_sel_s = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      idx        = (int'(ptr_q) + k) % NREQ;
      hit        = bus.req[idx] & ~any_req_s;
      sel_s      = hit ? PW'(idx) : sel_s;
      addr_sel_s = hit ? bus.req_addr[16*idx +: 16] : addr_sel_s;
      data_sel_s = hit ? bus.req_data[8*idx +: 8] : data_sel_s;
      any_req_s  = any_req_s | bus.req[idx];
    end
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
`ifdef I2C_ARB_TIMEOUT_EN
    err_d   = '0;
    wdog_d  = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_SETUP;
          gnt_d   = onehot(sel_s);
          addr_d  = addr_sel_s;
          data_d  = data_sel_s;
          sel_d   = sel_s;
          ptr_d   = (sel_s == PW'(NREQ - 1)) ? '0 : sel_s + PW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_START;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
        wdog_d  = 24'd0;
`endif
      end
      ST_WAIT_DONE: begin
        if (bus.i2c_done) begin
          ack_d   = onehot(sel_q);
          gnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wdog_q == TIMEOUT_CYCLES - 24'd1) begin
          err_d   = onehot(sel_q);
          gnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          wdog_d  = wdog_q + 24'd1;
        end
`else
        else begin
          state_d = ST_WAIT_DONE;
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gap_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      err_q   <= '0;
      wdog_q  <= 24'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
`ifdef I2C_ARB_TIMEOUT_EN
      err_q   <= err_d;
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.i2c_addr  = addr_q;
  assign bus.i2c_data  = data_q;
  assign bus.i2c_start = start_q;
  assign bus.busy      = busy_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = '0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: vector table, hand-written corner
// sequences and randomized transactions against a round-robin reference model.
module tb_i2c_req_arbiter;
  localparam int NREQ = 4;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_req_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] mask;
    int         delay;
    int         exp_win;
  } vec_t;

  vec_t        vecs[7];
  int          tests = 0;
  int          fails = 0;
  int          model_ptr = 0;
  logic [15:0] addr_tab[NREQ];
  logic [7:0]  data_tab[NREQ];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_tables();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[16*i +: 16] = addr_tab[i];
      bus.req_data[8*i +: 8]   = data_tab[i];
    end
  endtask

  // Reference: first set request at or after ptr, wrapping around.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called at a negedge with the arbiter idle; runs one full transaction.
  task automatic do_txn(input string nm, input logic [3:0] mask, input int delay,
                        input int exp_win, input bit spur, input bit drop);
    logic [3:0] oh;
    int busy_n;
    oh = 4'b0001 << exp_win;
    bus.req = mask;
    @(negedge clk);
    chk({nm, " gnt"}, 32'(bus.gnt), 32'(oh));
    chk({nm, " addr"}, 32'(bus.i2c_addr), 32'(addr_tab[exp_win]));
    chk({nm, " data"}, 32'(bus.i2c_data), 32'(data_tab[exp_win]));
    chk({nm, " setup start/busy"}, {30'd0, bus.i2c_start, bus.busy}, 32'd1);
    if (spur) bus.i2c_done = 1'b1;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    chk({nm, " start pulse"}, {27'd0, bus.i2c_start, bus.ack}, {27'd0, 1'b1, 4'd0});
    @(negedge clk);
    if (drop) bus.req[exp_win] = 1'b0;
    for (int c = 0; c < delay; c++) begin
      chk({nm, " wait"}, {23'd0, bus.ack, bus.i2c_start, bus.gnt}, {23'd0, 4'd0, 1'b0, oh});
      @(negedge clk);
    end
    chk({nm, " wait last"}, {27'd0, bus.i2c_start, bus.ack}, 32'd0);
    bus.i2c_done = 1'b1;
    @(negedge clk);
    bus.i2c_done = spur;
    chk({nm, " ack"}, {19'd0, bus.ack, bus.gnt, bus.err, bus.busy},
        {19'd0, oh, 4'd0, 4'd0, 1'b1});
    bus.req[exp_win] = 1'b0;
    model_ptr = (exp_win + 1) % NREQ;
    busy_n = 1;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    while (bus.busy && busy_n < 20) begin
      chk({nm, " gap"}, {24'd0, bus.ack, bus.gnt}, 32'd0);
      busy_n++;
      @(negedge clk);
    end
    chk({nm, " gap length"}, 32'(busy_n), 32'(GAP));
  endtask

  initial begin
    logic [3:0] m;
    int         w;
    reset        = 1'b0;
    bus.req      = '0;
    bus.i2c_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_tab[i] = 16'h1000 + 16'(i * 16'h0111);
      data_tab[i] = 8'h10 + 8'(i);
    end
    addr_tab[2] = 16'h3008;
    data_tab[2] = 8'h82;
    drive_tables();

    vecs[0] = '{4'b0100, 19, 2};
    vecs[1] = '{4'b0111, 0, 0};
    vecs[2] = '{4'b1111, 3, 1};
    vecs[3] = '{4'b1001, 1, 3};
    vecs[4] = '{4'b0010, 5, 1};
    vecs[5] = '{4'b0011, 2, 0};
    vecs[6] = '{4'b1000, 0, 3};

    repeat (3) @(negedge clk);
    chk("reset outs", {15'd0, bus.gnt, bus.ack, bus.err, bus.i2c_start, bus.busy}, 32'd0);
    chk("reset addr/data", {8'd0, bus.i2c_addr, bus.i2c_data}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Spurious done while idle must not start anything.
    bus.i2c_done = 1'b1;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    chk("idle spur", {23'd0, bus.busy, bus.ack, bus.gnt}, 32'd0);
    @(negedge clk);
    chk("idle spur 2", {23'd0, bus.busy, bus.ack, bus.gnt}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].delay, vecs[i].exp_win, 1'b0, 1'b0);
    end

    // All four requesting continuously: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      do_txn($sformatf("allreq%0d", i), 4'b1111, 2, i % NREQ, 1'b0, 1'b0);
    end

    do_txn("drop", 4'b1110, 4, 1, 1'b0, 1'b1);
    do_txn("after drop", 4'b1100, 1, 2, 1'b0, 1'b0);
    do_txn("spur", 4'b0001, 3, 0, 1'b1, 1'b0);

    // Reset in WAIT_DONE after a grant to 1 (pointer would be 2 without reset).
    do_txn("pre reset", 4'b0010, 0, 1, 1'b0, 1'b0);
    bus.req = 4'b1111;
    repeat (4) @(negedge clk);
    chk("wd gnt", 32'(bus.gnt), 32'h4);
    reset = 1'b0;
    #1;
    chk("rst async outs", {15'd0, bus.gnt, bus.ack, bus.err, bus.i2c_start, bus.busy}, 32'd0);
    chk("rst async addr", {8'd0, bus.i2c_addr, bus.i2c_data}, 32'd0);
    @(negedge clk);
    bus.req = '0;
    reset   = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    chk("rst no ack", {28'd0, bus.ack}, 32'd0);
    do_txn("post rst rr", 4'b1111, 1, 0, 1'b0, 1'b0);
    do_txn("post rst r3", 4'b1000, 1, 3, 1'b0, 1'b0);

    // Randomized transactions checked against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        addr_tab[j] = 16'($urandom);
        data_tab[j] = 8'($urandom);
      end
      drive_tables();
      m = 4'($urandom_range(1, 15));
      w = rr_pick(m, model_ptr);
      do_txn($sformatf("rnd%0d", i), m, $urandom_range(0, 6), w,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
